// File: rtl/shared_tap_line.sv
// shared_tap_line: shared circular delay line for serial MAC filter banks.
// Captures one sample every PHASES enabled clocks and streams its taps.
//
// Ports:
//   clock, reset     sole clock, synchronous active-high reset
//   clk_enable       global advance qualifier
//   filter_in        signed sample, written on the ph==0 enabled edge
//   sample_strobe    one-cycle pulse after each write edge
//   tap_valid        tap outputs carry a new step this cycle
//   tap_first/last   step 0 / step NSTEPS-1 markers
//   tap_idx          tap index k of tap_a
//   tap_a, tap_b     tap k and, in symmetric mode, tap TAPS-1-k
module shared_tap_line #(
  parameter int DATA_W    = 13,
  parameter int TAPS      = 119,
  parameter int PHASES    = 61,
  parameter bit SYMMETRIC = 1'b1,
  localparam int IW = $clog2(TAPS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic signed [DATA_W-1:0] filter_in,
  output logic                     sample_strobe,
  output logic                     tap_valid,
  output logic                     tap_first,
  output logic                     tap_last,
  output logic [IW-1:0]            tap_idx,
  output logic signed [DATA_W-1:0] tap_a,
  output logic signed [DATA_W-1:0] tap_b
);

  localparam int NSTEPS = SYMMETRIC ? (TAPS + 1) / 2 : TAPS;
  localparam int PW = $clog2(PHASES);
  localparam int FW = $clog2(TAPS + 1);

  localparam logic [PW-1:0] PH_LAST  = PW'(PHASES - 1);
  localparam logic [PW-1:0] PH_NS    = PW'(NSTEPS);
  localparam logic [IW-1:0] IDX_LAST = IW'(NSTEPS - 1);
  localparam logic [IW-1:0] WP_LAST  = IW'(TAPS - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(TAPS);

  if (TAPS < 2) begin : g_bad_taps
    $error("shared_tap_line: TAPS must be at least 2");
  end

  if (PHASES < NSTEPS + 1) begin : g_bad_phases
    $error("shared_tap_line: PHASES must be at least NSTEPS+1");
  end

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [IW-1:0] addr_a;
    logic [IW-1:0] addr_b;
    logic          zero_a;
    logic          zero_b;
  } rd_req_t;

  logic [PW-1:0] ph;
  logic [PW-1:0] ph_nxt;
  logic [IW-1:0] wptr;
  logic [IW-1:0] wptr_nxt;
  logic [IW-1:0] wptr_last;
  logic [IW-1:0] newest;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_inc;
  logic [FW-1:0] fill_cur;
  logic          wr_edge;
  logic          ld_edge;
  rd_req_t       req;
  rd_req_t       req_nxt;

  logic signed [DATA_W-1:0] mem [TAPS];

  function automatic logic [IW-1:0] rd_addr(
    input logic [IW-1:0] base,
    input int            k
  );
    int t;
    t = int'(base) - k;
    if (t < 0) t = t + TAPS;
    return IW'(t);
  endfunction

  always_comb begin
    wr_edge  = clk_enable && (ph == '0);
    ld_edge  = clk_enable && (ph != '0) && (ph <= PH_NS);
    ph_nxt   = (ph == PH_LAST) ? '0 : ph + PW'(1);
    wptr_nxt = (wptr == WP_LAST) ? '0 : wptr + IW'(1);
    fill_inc = (fill == FILL_MAX) ? fill : fill + FW'(1);
  end

  // Step s addresses are formed on the ph==s edge. On the write edge
  // the sample being written is already the newest tap.
  always_comb begin
    int s;
    int kb;
    newest   = (ph == '0) ? wptr : wptr_last;
    fill_cur = (ph == '0) ? fill_inc : fill;
    s        = int'(ph);
    kb       = TAPS - 1 - s;
    req_nxt  = req;
    if (ph < PH_NS) begin
      req_nxt.idx    = IW'(s);
      req_nxt.addr_a = rd_addr(newest, s);
      req_nxt.addr_b = rd_addr(newest, kb);
      req_nxt.zero_a = s >= int'(fill_cur);
      // centre tap of an odd line is carried by tap_a only
      req_nxt.zero_b = !SYMMETRIC || (kb == s) ||
                       (kb >= int'(fill_cur));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ph        <= '0;
      wptr      <= '0;
      wptr_last <= '0;
      fill      <= '0;
      req       <= '0;
    end else if (clk_enable) begin
      ph  <= ph_nxt;
      req <= req_nxt;
      if (wr_edge) begin
        wptr      <= wptr_nxt;
        wptr_last <= wptr;
        fill      <= fill_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_edge) begin
      mem[wptr] <= filter_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sample_strobe <= 1'b0;
      tap_valid     <= 1'b0;
      tap_first     <= 1'b0;
      tap_last      <= 1'b0;
      tap_idx       <= '0;
      tap_a         <= '0;
      tap_b         <= '0;
    end else begin
      sample_strobe <= wr_edge;
      tap_valid     <= ld_edge;
      tap_first     <= 1'b0;
      tap_last      <= 1'b0;
      if (ld_edge) begin
        tap_first <= (req.idx == '0);
        tap_last  <= (req.idx == IDX_LAST);
        tap_idx   <= req.idx;
        tap_a     <= req.zero_a ? '0 : mem[req.addr_a];
        tap_b     <= req.zero_b ? '0 : mem[req.addr_b];
      end
    end
  end

endmodule

// File: tb/tb_shared_tap_line.sv
// tb_shared_tap_line: randomized bench for shared_tap_line.
// Three configurations checked against a sample-history model.
module tb_shared_tap_line;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               rst [3];
  logic               en  [3];
  logic signed [12:0] din [3];

  logic               d0_strobe, d0_valid, d0_first, d0_last;
  logic [6:0]         d0_idx;
  logic signed [12:0] d0_a, d0_b;
  logic               d1_strobe, d1_valid, d1_first, d1_last;
  logic [2:0]         d1_idx;
  logic signed [12:0] d1_a, d1_b;
  logic               d2_strobe, d2_valid, d2_first, d2_last;
  logic [1:0]         d2_idx;
  logic signed [12:0] d2_a, d2_b;

  shared_tap_line u_d0 (
    .clock(clock), .reset(rst[0]), .clk_enable(en[0]),
    .filter_in(din[0]), .sample_strobe(d0_strobe),
    .tap_valid(d0_valid), .tap_first(d0_first),
    .tap_last(d0_last), .tap_idx(d0_idx),
    .tap_a(d0_a), .tap_b(d0_b)
  );

  shared_tap_line #(.TAPS(5), .PHASES(4), .SYMMETRIC(1'b1)) u_d1 (
    .clock(clock), .reset(rst[1]), .clk_enable(en[1]),
    .filter_in(din[1]), .sample_strobe(d1_strobe),
    .tap_valid(d1_valid), .tap_first(d1_first),
    .tap_last(d1_last), .tap_idx(d1_idx),
    .tap_a(d1_a), .tap_b(d1_b)
  );

  shared_tap_line #(.TAPS(4), .PHASES(5), .SYMMETRIC(1'b0)) u_d2 (
    .clock(clock), .reset(rst[2]), .clk_enable(en[2]),
    .filter_in(din[2]), .sample_strobe(d2_strobe),
    .tap_valid(d2_valid), .tap_first(d2_first),
    .tap_last(d2_last), .tap_idx(d2_idx),
    .tap_a(d2_a), .tap_b(d2_b)
  );

  logic [3:0] obs_f [3];
  integer     obs_i [3];
  integer     obs_a [3];
  integer     obs_b [3];

  always_comb begin
    obs_f[0] = {d0_valid, d0_first, d0_last, d0_strobe};
    obs_i[0] = d0_idx;
    obs_a[0] = d0_a;
    obs_b[0] = d0_b;
    obs_f[1] = {d1_valid, d1_first, d1_last, d1_strobe};
    obs_i[1] = d1_idx;
    obs_a[1] = d1_a;
    obs_b[1] = d1_b;
    obs_f[2] = {d2_valid, d2_first, d2_last, d2_strobe};
    obs_i[2] = d2_idx;
    obs_a[2] = d2_a;
    obs_b[2] = d2_b;
  end

  int tcfg [3] = '{119, 5, 4};
  int pcfg [3] = '{61, 4, 5};
  int scfg [3] = '{1, 1, 0};

  int nen  [3];
  int hcnt [3];
  int hmem [3][128];
  bit ev [3];
  bit ef [3];
  bit el [3];
  bit es [3];
  int ei [3];
  int ea [3];
  int eb [3];

  int total = 0;
  int bad = 0;

  function automatic int nsteps(input int d);
    return (scfg[d] != 0) ? (tcfg[d] + 1) / 2 : tcfg[d];
  endfunction

  // tap k = sample written k writes before the newest, 0 if never written
  function automatic int tap_of(input int d, input int k);
    if (k >= hcnt[d] || k >= tcfg[d]) return 0;
    return hmem[d][(hcnt[d] - 1 - k) % 128];
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(8191)) - 4096;
  endfunction

  function automatic logic [43:0] got_of(input int d);
    return {obs_f[d], obs_i[d][7:0], obs_a[d][15:0], obs_b[d][15:0]};
  endfunction

  function automatic logic [43:0] want_of(input int d);
    return {ev[d], ef[d], el[d], es[d],
            ei[d][7:0], ea[d][15:0], eb[d][15:0]};
  endfunction

  // drive one clock for instance d and advance its reference model
  task automatic tick(input int d, input logic r,
                      input logic e, input int x);
    int ph;
    int s;
    int kb;
    int ns;
    rst[d] = r;
    en[d]  = e;
    din[d] = 13'(x);
    @(posedge clock);
    ev[d] = 1'b0;
    ef[d] = 1'b0;
    el[d] = 1'b0;
    es[d] = 1'b0;
    if (r) begin
      nen[d]  = 0;
      hcnt[d] = 0;
      ei[d]   = 0;
      ea[d]   = 0;
      eb[d]   = 0;
    end else if (e) begin
      ph = nen[d] % pcfg[d];
      ns = nsteps(d);
      if (ph == 0) begin
        hmem[d][hcnt[d] % 128] = x;
        hcnt[d]++;
        es[d] = 1'b1;
      end else if (ph <= ns) begin
        s     = ph - 1;
        kb    = tcfg[d] - 1 - s;
        ev[d] = 1'b1;
        ef[d] = (s == 0);
        el[d] = (s == ns - 1);
        ei[d] = s;
        ea[d] = tap_of(d, s);
        eb[d] = (scfg[d] != 0 && kb != s) ? tap_of(d, kb) : 0;
      end
      nen[d]++;
    end
    #1;
  endtask

  task automatic test_reset();
    int v;
    for (int i = 0; i < 3; i++) begin
      tick(0, 1'b1, 1'b1, rnd_sample());
      if (got_of(0) !== 44'd0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h want=0", i, got_of(0));
      end
      total++;
    end
    v = rnd_sample();
    tick(0, 1'b0, 1'b1, v);
    if (got_of(0) !== want_of(0) || d0_strobe !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_write got=%h want=%h",
               got_of(0), want_of(0));
    end
    total++;
    tick(0, 1'b0, 1'b1, rnd_sample());
    if (d0_valid !== 1'b1 || d0_first !== 1'b1 || d0_idx !== 7'd0 ||
        obs_a[0] !== v || obs_b[0] !== 0) begin
      bad++;
      $display("FAIL reset_step0 got v=%b i=%0d a=%0d b=%0d want a=%0d",
               d0_valid, d0_idx, obs_a[0], obs_b[0], v);
    end
    total++;
  endtask

  task automatic test_sym_fill();
    int xi [3] = '{0, 1, 2};
    int xa [3] = '{5, 4, 3};
    int xb [3] = '{1, 2, 0};
    int ri [8];
    int ra [8];
    int rb [8];
    bit rf [8];
    bit rl [8];
    int n = 0;
    tick(1, 1'b1, 1'b1, 0);
    tick(1, 1'b1, 1'b1, 0);
    for (int v = 1; v <= 6; v++) begin
      for (int c = 0; c < 4; c++) begin
        tick(1, 1'b0, 1'b1, v);
        if (got_of(1) !== want_of(1)) begin
          bad++;
          $display("FAIL sym_model v=%0d c=%0d got=%h want=%h",
                   v, c, got_of(1), want_of(1));
        end
        total++;
        if (v == 5 && d1_valid === 1'b1 && n < 8) begin
          ri[n] = obs_i[1];
          ra[n] = obs_a[1];
          rb[n] = obs_b[1];
          rf[n] = d1_first;
          rl[n] = d1_last;
          n++;
        end
        if (v == 6 && c == 1) begin
          if (d1_valid !== 1'b1 || obs_i[1] !== 0 ||
              obs_a[1] !== 6 || obs_b[1] !== 2) begin
            bad++;
            $display("FAIL sym_sixth got v=%b i=%0d a=%0d b=%0d want 1/0/6/2",
                     d1_valid, obs_i[1], obs_a[1], obs_b[1]);
          end
          total++;
        end
      end
    end
    if (n !== 3) begin
      bad++;
      $display("FAIL sym_count got=%0d want=3", n);
    end
    total++;
    for (int j = 0; j < 3 && j < n; j++) begin
      if (ri[j] !== xi[j] || ra[j] !== xa[j] || rb[j] !== xb[j] ||
          rf[j] !== (j == 0) || rl[j] !== (j == 2)) begin
        bad++;
        $display("FAIL sym_step%0d got=(%0d,%0d,%0d,%b,%b) want=(%0d,%0d,%0d)",
                 j, ri[j], ra[j], rb[j], rf[j], rl[j], xi[j], xa[j], xb[j]);
      end
      total++;
    end
  endtask

  task automatic test_warmup();
    int xa [3] = '{7, 0, 0};
    int n = 0;
    tick(1, 1'b1, 1'b1, 0);
    for (int c = 0; c < 4; c++) begin
      tick(1, 1'b0, 1'b1, 7);
      if (got_of(1) !== want_of(1)) begin
        bad++;
        $display("FAIL warm_model c=%0d got=%h want=%h",
                 c, got_of(1), want_of(1));
      end
      total++;
      if (d1_valid === 1'b1) begin
        if (n > 2 || obs_i[1] !== n || obs_a[1] !== xa[n] ||
            obs_b[1] !== 0) begin
          bad++;
          $display("FAIL warm_step got=(%0d,%0d,%0d) n=%0d",
                   obs_i[1], obs_a[1], obs_b[1], n);
        end
        total++;
        n++;
      end
    end
    if (n !== 3) begin
      bad++;
      $display("FAIL warm_count got=%0d want=3", n);
    end
    total++;
  endtask

  task automatic test_nonsym();
    int vals [5] = '{-3, 8, 2, -1, 6};
    int xa [4] = '{6, -1, 2, 8};
    int n = 0;
    tick(2, 1'b1, 1'b1, 0);
    tick(2, 1'b1, 1'b1, 0);
    for (int v = 0; v < 5; v++) begin
      for (int c = 0; c < 5; c++) begin
        tick(2, 1'b0, 1'b1, vals[v]);
        if (got_of(2) !== want_of(2)) begin
          bad++;
          $display("FAIL nonsym_model v=%0d c=%0d got=%h want=%h",
                   v, c, got_of(2), want_of(2));
        end
        total++;
        if (v == 4 && d2_valid === 1'b1) begin
          if (n > 3 || obs_i[2] !== n || obs_a[2] !== xa[n] ||
              obs_b[2] !== 0 || d2_first !== (n == 0) ||
              d2_last !== (n == 3)) begin
            bad++;
            $display("FAIL nonsym_step got=(%0d,%0d,%0d) n=%0d",
                     obs_i[2], obs_a[2], obs_b[2], n);
          end
          total++;
          n++;
        end
      end
    end
    if (n !== 4) begin
      bad++;
      $display("FAIL nonsym_count got=%0d want=4", n);
    end
    total++;
  endtask

  task automatic test_enable_gaps();
    bit pv = 1'b0;
    int pidx = -1;
    int want;
    int n = 0;
    tick(0, 1'b1, 1'b1, 0);
    tick(0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 3 * 61 * 2; i++) begin
      tick(0, 1'b0, (i % 2) == 0, rnd_sample());
      if (got_of(0) !== want_of(0)) begin
        bad++;
        $display("FAIL gaps_model i=%0d got=%h want=%h",
                 i, got_of(0), want_of(0));
      end
      total++;
      if (d0_valid === 1'b1) begin
        want = (d0_first === 1'b1) ? 0 : pidx + 1;
        if (pv || obs_i[0] !== want) begin
          bad++;
          $display("FAIL gaps_seq i=%0d got idx=%0d prev_valid=%b want=%0d",
                   i, obs_i[0], pv, want);
        end
        total++;
        pidx = obs_i[0];
        n++;
      end
      pv = (d0_valid === 1'b1);
    end
    if (n !== 180) begin
      bad++;
      $display("FAIL gaps_count got=%0d want=180", n);
    end
    total++;
    for (int i = 0; i < 400; i++) begin
      tick(0, 1'b0, $urandom_range(1) == 1, rnd_sample());
      if (got_of(0) !== want_of(0)) begin
        bad++;
        $display("FAIL rand_en i=%0d got=%h want=%h",
                 i, got_of(0), want_of(0));
      end
      total++;
    end
  endtask

  task automatic test_midreset();
    bit found = 1'b0;
    int v;
    tick(0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 400 && !found; i++) begin
      tick(0, 1'b0, 1'b1, rnd_sample());
      if (got_of(0) !== want_of(0)) begin
        bad++;
        $display("FAIL mid_model i=%0d got=%h want=%h",
                 i, got_of(0), want_of(0));
      end
      total++;
      if (i >= 122 && ev[0] && ei[0] == 30) found = 1'b1;
    end
    if (!found) begin
      bad++;
      $display("FAIL mid_step30 got=timeout want=step 30");
    end
    total++;
    tick(0, 1'b1, 1'b1, 0);
    if (got_of(0) !== 44'd0) begin
      bad++;
      $display("FAIL mid_clear got=%h want=0", got_of(0));
    end
    total++;
    v = rnd_sample();
    if (v == 0) v = 1;
    for (int c = 0; c < 61; c++) begin
      tick(0, 1'b0, 1'b1, (c == 0) ? v : rnd_sample());
      if (got_of(0) !== want_of(0)) begin
        bad++;
        $display("FAIL mid_after c=%0d got=%h want=%h",
                 c, got_of(0), want_of(0));
      end
      total++;
      if (d0_valid === 1'b1) begin
        if (obs_b[0] !== 0 ||
            (obs_i[0] == 0 && obs_a[0] !== v) ||
            (obs_i[0] != 0 && obs_a[0] !== 0)) begin
          bad++;
          $display("FAIL mid_mask got=(%0d,%0d,%0d) want a=%0d at idx 0",
                   obs_i[0], obs_a[0], obs_b[0], v);
        end
        total++;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d]  = 1'b1;
      en[d]   = 1'b0;
      din[d]  = '0;
      nen[d]  = 0;
      hcnt[d] = 0;
      ev[d]   = 1'b0;
      ef[d]   = 1'b0;
      el[d]   = 1'b0;
      es[d]   = 1'b0;
      ei[d]   = 0;
      ea[d]   = 0;
      eb[d]   = 0;
    end
    test_reset();
    test_sym_fill();
    test_warmup();
    test_nonsym();
    test_enable_gaps();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
